sdram_host_arbiter: RTL and testbench
=====================================

# sdram_host_arbiter

Two-port arbiter and sequencer for the SDRAM controller host interface (wr_addr/wr_data/wr_enable, rd_addr/rd_enable/rd_ready/rd_data, busy), in the SDRAM clock domain. It grants single-word read or write requests from two requesters round-robin and issues exactly one host command at a time. It tracks each command through the controller's busy handshake and returns read data to the requester that issued the read. A watchdog recovers if the controller never acknowledges a command.

## Interface
Parameters:
- HADDR_WIDTH, 24, host word address width
- HDATA_WIDTH, 16, host data width
- ACK_TIMEOUT, 15, max cycles in WAIT_ACK before abort (≥1)

Ports:
- SDRAM_CLK  in  1  sole clock, rising edge
- ARESETn  in  1  reset, asynchronous assert, active-low
- p0_req, p1_req  in  1  request valid; must stay high, fields stable, until pN_gnt
- p0_we, p1_we  in  1  1 = write, 0 = read
- p0_addr, p1_addr  in  HADDR_WIDTH  word address
- p0_wdata, p1_wdata  in  HDATA_WIDTH  write data
- p0_gnt, p1_gnt  out  1  one-cycle accept pulse
- p0_rvalid, p1_rvalid  out  1  one-cycle read-data-valid pulse
- p0_rdata, p1_rdata  out  HDATA_WIDTH  read data, held until that port's next read completes
- wr_addr, rd_addr  out  HADDR_WIDTH  controller addresses
- wr_data  out  HDATA_WIDTH  controller write data
- wr_enable, rd_enable  out  1  controller command pulses
- rd_data  in  HDATA_WIDTH  controller read data
- rd_ready  in  1  controller read-data strobe
- busy  in  1  controller busy
- err  out  1  one-cycle error pulse
- err_port  out  1  port of the last errored command

## Operation
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE: if busy=0 and any req is high, pick the winner, latch its we/addr/wdata and the port id (cur), and go to ISSUE. Otherwise stay.
- Arbitration: with one requester, it wins. With both, the port ≠ last_grant wins. last_grant updates on every grant and resets to 1, so port 0 wins the first tie.
- ISSUE (exactly 1 cycle): pcur_gnt=1. If writing, wr_enable=1; otherwise rd_enable=1. Go to WAIT_ACK and clear the ack counter.
- WAIT_ACK: on busy=1 go to WAIT_DONE. Otherwise increment the counter. When the counter reaches ACK_TIMEOUT, pulse err, set err_port=cur, and go to IDLE.
- WAIT_DONE, write: on busy=0 go to IDLE.
- WAIT_DONE, read: on rd_ready=1, capture rd_data into pcur_rdata and set a done flag. On busy=0, go to IDLE. If done was not set (rd_ready was not seen), pulse err, set err_port=cur, and issue no rvalid.
- rd_ready and busy=0 in the same cycle: capture the data, no error, go to IDLE.
- rd_ready outside WAIT_DONE of a read: ignored.
- wr_addr/rd_addr/wr_data are driven from the latched command registers and stay stable from ISSUE until the next grant.
- Reset (any time, including mid-command): state=IDLE, last_grant=1, done=0, counter=0. All outputs go to 0, including rdata and address/data registers. In-flight commands are dropped without err.

## Timing
- Request to gnt/enable: req sampled in IDLE at edge N, then gnt and enable high in cycle N+1 (registered, one cycle wide).
- Minimum write occupancy: ISSUE + WAIT_ACK (≥1) + WAIT_DONE (≥1), plus 1 IDLE cycle, so back-to-back grants are ≥4 cycles apart.
- Read data return: rd_ready sampled at edge M, then pcur_rvalid=1 and pcur_rdata valid in cycle M+1.
- err: high for one cycle, registered, the cycle after the abort condition is sampled.
- Timeout: with busy stuck at 0, err is asserted ACK_TIMEOUT+1 cycles after the ISSUE cycle, then IDLE.
- No command is issued while busy=1 in IDLE. Requests are held, never dropped.
- gnt never asserts on both ports in the same cycle. Only one rvalid can be high in any cycle.

## Test plan
- Single write: p0_req=1, we=1, addr=0x000010, wdata=0xBEEF. Controller model raises busy 1 cycle after wr_enable for 5 cycles. Required: p0_gnt and wr_enable in the same cycle, wr_addr=0x000010, wr_data=0xBEEF, no err, back in IDLE after busy falls.
- Tie fairness: p0 and p1 both request reads continuously. Required grant order p0, p1, p0, p1; never two consecutive grants to the same port while both are requesting.
- Read return: p1 reads addr 0x0000A5. Model drives rd_data=0x1234 with a rd_ready pulse, then drops busy. Required: p1_rvalid exactly 1 cycle after rd_ready, p1_rdata=0x1234, p0_rvalid=0, p0_rdata unchanged.
- Ack timeout: busy held at 0 after a p0 write issue, ACK_TIMEOUT=15. Required: err=1, err_port=0 exactly 16 cycles after ISSUE. A subsequent p1 request is granted normally.
- Read without data: p0 read where busy rises then falls with no rd_ready. Required: err=1, err_port=0, p0_rvalid never asserted.
- Reset mid-read: ARESETn low during WAIT_DONE. Required: all outputs 0 immediately (asynchronously). After release with both requesting, p0 is granted first.

Source files
------------

// File: rtl/sdram_host_arbiter.sv
// Two-port round-robin arbiter and single-command sequencer for the SDRAM controller host port.
// Tracks the busy handshake with an ack watchdog and routes read data back to the issuing port.
module sdram_host_arbiter #(
  parameter int HADDR_WIDTH = 24,
  parameter int HDATA_WIDTH = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                   SDRAM_CLK,
  input  logic                   ARESETn,
  input  logic                   p0_req,
  input  logic                   p0_we,
  input  logic [HADDR_WIDTH-1:0] p0_addr,
  input  logic [HDATA_WIDTH-1:0] p0_wdata,
  output logic                   p0_gnt,
  output logic                   p0_rvalid,
  output logic [HDATA_WIDTH-1:0] p0_rdata,
  input  logic                   p1_req,
  input  logic                   p1_we,
  input  logic [HADDR_WIDTH-1:0] p1_addr,
  input  logic [HDATA_WIDTH-1:0] p1_wdata,
  output logic                   p1_gnt,
  output logic                   p1_rvalid,
  output logic [HDATA_WIDTH-1:0] p1_rdata,
  output logic [HADDR_WIDTH-1:0] wr_addr,
  output logic [HDATA_WIDTH-1:0] wr_data,
  output logic                   wr_enable,
  output logic [HADDR_WIDTH-1:0] rd_addr,
  output logic                   rd_enable,
  input  logic [HDATA_WIDTH-1:0] rd_data,
  input  logic                   rd_ready,
  input  logic                   busy,
  output logic                   err,
  output logic                   err_port
);

  localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  state_t                 r_state;
  logic                   r_last;
  logic                   r_cur;
  logic                   r_we;
  logic [HADDR_WIDTH-1:0] r_addr;
  logic [HDATA_WIDTH-1:0] r_wdata;
  logic [CW-1:0]          r_cnt;
  logic                   r_done;
  logic [1:0]             r_gnt;
  logic [1:0]             r_rvalid;
  logic [HDATA_WIDTH-1:0] r_rdata0;
  logic [HDATA_WIDTH-1:0] r_rdata1;
  logic                   r_wr_en;
  logic                   r_rd_en;
  logic                   r_err;
  logic                   r_err_port;

  logic                   w_any;
  logic                   w_pick;
  logic                   w_we;
  logic [HADDR_WIDTH-1:0] w_addr;
  logic [HDATA_WIDTH-1:0] w_wdata;

  // On a tie the port that did not win last time goes next.
  assign w_any   = p0_req | p1_req;
  assign w_pick  = (p0_req & p1_req) ? ~r_last : p1_req;
  assign w_we    = w_pick ? p1_we    : p0_we;
  assign w_addr  = w_pick ? p1_addr  : p0_addr;
  assign w_wdata = w_pick ? p1_wdata : p0_wdata;

  always_ff @(posedge SDRAM_CLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state    <= IDLE;
      r_last     <= 1'b1;
      r_cur      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_gnt      <= 2'b00;
      r_rvalid   <= 2'b00;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
      r_wr_en    <= 1'b0;
      r_rd_en    <= 1'b0;
      r_err      <= 1'b0;
      r_err_port <= 1'b0;
    end else begin
      r_gnt    <= 2'b00;
      r_rvalid <= 2'b00;
      r_wr_en  <= 1'b0;
      r_rd_en  <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!busy && w_any) begin
            r_cur   <= w_pick;
            r_last  <= w_pick;
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_gnt   <= w_pick ? 2'b10 : 2'b01;
            r_wr_en <= w_we;
            r_rd_en <= ~w_we;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_done  <= 1'b0;
          r_state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (busy) begin
            r_state <= WAIT_DONE;
          end else if (r_cnt == ACK_LAST) begin
            r_err      <= 1'b1;
            r_err_port <= r_cur;
            r_state    <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!r_we && rd_ready) begin
            if (r_cur) r_rdata1 <= rd_data;
            else       r_rdata0 <= rd_data;
            r_rvalid[r_cur] <= 1'b1;
            r_done          <= 1'b1;
          end
          // A read that finishes without ever strobing rd_ready is reported, not returned.
          if (!busy) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            if (!r_we && !r_done && !rd_ready) begin
              r_err      <= 1'b1;
              r_err_port <= r_cur;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign p0_gnt    = r_gnt[0];
  assign p1_gnt    = r_gnt[1];
  assign p0_rvalid = r_rvalid[0];
  assign p1_rvalid = r_rvalid[1];
  assign p0_rdata  = r_rdata0;
  assign p1_rdata  = r_rdata1;
  assign wr_addr   = r_addr;
  assign rd_addr   = r_addr;
  assign wr_data   = r_wdata;
  assign wr_enable = r_wr_en;
  assign rd_enable = r_rd_en;
  assign err       = r_err;
  assign err_port  = r_err_port;

endmodule

// File: tb/tb_sdram_host_arbiter.sv
// Scoreboard bench for sdram_host_arbiter: directed requests push expected grant/rvalid/err events,
// a monitor pops and compares them, and a small controller model answers the host commands.
module tb_sdram_host_arbiter;

  localparam int K_GNT = 0;
  localparam int K_RV  = 1;
  localparam int K_ERR = 2;

  typedef struct {
    int          kind;
    int          port;
    logic        we;
    logic [23:0] addr;
    logic [15:0] data;
    int          dly;
  } exp_t;

  logic        SDRAM_CLK;
  logic        ARESETn;
  logic        req   [2];
  logic        we    [2];
  logic [23:0] addr  [2];
  logic [15:0] wdata [2];
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [15:0] p0_rdata, p1_rdata;
  logic [23:0] wr_addr, rd_addr;
  logic [15:0] wr_data, rd_data;
  logic        wr_enable, rd_enable, rd_ready, busy, err, err_port;

  exp_t        sb[$];
  int          n_chk;
  int          n_pass;
  int          cyc;
  int          last_cyc;
  logic [15:0] hold [2];

  // Controller model controls
  logic        m_ack, m_rdy, m_fix, m_act, m_we;
  logic [15:0] m_rdata;
  logic [23:0] m_addr;
  int          m_k;

  sdram_host_arbiter dut (
    .SDRAM_CLK(SDRAM_CLK), .ARESETn(ARESETn),
    .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
    .rd_addr(rd_addr), .rd_enable(rd_enable), .rd_data(rd_data),
    .rd_ready(rd_ready), .busy(busy), .err(err), .err_port(err_port)
  );

  initial begin
    SDRAM_CLK = 1'b0;
    forever #5 SDRAM_CLK = ~SDRAM_CLK;
  end

  initial cyc = 0;
  always @(posedge SDRAM_CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input int kind, input int port, input logic w, input logic [23:0] a,
                      input logic [15:0] d, input int dly);
    exp_t e;
    e.kind = kind; e.port = port; e.we = w; e.addr = a; e.data = d; e.dly = dly;
    sb.push_back(e);
  endtask

  task automatic check_zero();
    chk("rst_p0_gnt",    32'(p0_gnt),    0);
    chk("rst_p1_gnt",    32'(p1_gnt),    0);
    chk("rst_wr_enable", 32'(wr_enable), 0);
    chk("rst_rd_enable", 32'(rd_enable), 0);
    chk("rst_wr_addr",   32'(wr_addr),   0);
    chk("rst_rd_addr",   32'(rd_addr),   0);
    chk("rst_wr_data",   32'(wr_data),   0);
    chk("rst_err",       32'(err),       0);
    chk("rst_err_port",  32'(err_port),  0);
    chk("rst_p0_rvalid", 32'(p0_rvalid), 0);
    chk("rst_p1_rvalid", 32'(p1_rvalid), 0);
    chk("rst_p0_rdata",  32'(p0_rdata),  0);
    chk("rst_p1_rdata",  32'(p1_rdata),  0);
  endtask

  task automatic evt(input int kind, input int port);
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL unexpected_event: kind %0d on port %0d at cycle %0d, none expected", kind, port, cyc);
      return;
    end
    e = sb.pop_front();
    chk("event_kind", 32'(kind), 32'(e.kind));
    chk("event_port", 32'(port), 32'(e.port));
    if (e.dly >= 0) chk("event_delay", 32'(cyc - last_cyc), 32'(e.dly));
    last_cyc = cyc;
    if (kind == K_GNT && e.kind == K_GNT) begin
      chk("wr_enable", 32'(wr_enable), 32'(e.we));
      chk("rd_enable", 32'(rd_enable), 32'(!e.we));
      if (e.we) begin
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", 32'(wr_data), 32'(e.data));
      end else begin
        chk("rd_addr", 32'(rd_addr), 32'(e.addr));
      end
    end else if (kind == K_RV && e.kind == K_RV) begin
      chk("rdata", 32'(port != 0 ? p1_rdata : p0_rdata), 32'(e.data));
      chk("other_rdata_held", 32'(port != 0 ? p0_rdata : p1_rdata), 32'(hold[port != 0 ? 0 : 1]));
      hold[port] = e.data;
    end
  endtask

  // Monitor
  initial begin
    last_cyc = 0;
    hold[0] = '0;
    hold[1] = '0;
    forever begin
      @(negedge SDRAM_CLK);
      if (!ARESETn) begin
        hold[0] = '0;
        hold[1] = '0;
      end else begin
        if (p0_gnt || p1_gnt) begin
          chk("single_gnt", 32'(p0_gnt & p1_gnt), 0);
          evt(K_GNT, int'(p1_gnt));
        end
        if (wr_enable || rd_enable) chk("enable_with_gnt", 32'(p0_gnt | p1_gnt), 1);
        if (p0_rvalid || p1_rvalid) begin
          chk("single_rvalid", 32'(p0_rvalid & p1_rvalid), 0);
          evt(K_RV, int'(p1_rvalid));
        end
        if (err) evt(K_ERR, int'(err_port));
      end
    end
  end

  // Controller model: busy high for 5 cycles starting the cycle after a command,
  // rd_ready pulsed in the 4th cycle for reads.
  initial begin
    busy = 1'b0; rd_ready = 1'b0; rd_data = '0;
    m_act = 1'b0; m_we = 1'b0; m_k = 0; m_addr = '0;
    forever begin
      @(negedge SDRAM_CLK);
      if (!ARESETn) begin
        m_act = 1'b0; busy = 1'b0; rd_ready = 1'b0; rd_data = '0;
      end else if (m_act) begin
        m_k++;
        busy     = m_ack && m_k >= 1 && m_k <= 5;
        rd_ready = m_rdy && !m_we && m_k == 4;
        rd_data  = !rd_ready ? 16'h0000 : (m_fix ? m_rdata : (m_addr[15:0] ^ 16'hC3C3));
        if (m_k >= 6) m_act = 1'b0;
      end else if (wr_enable || rd_enable) begin
        m_act = 1'b1; m_k = 0; m_we = wr_enable; m_addr = rd_addr;
      end
    end
  end

  task automatic do_req(input int p, input logic w, input logic [23:0] a, input logic [15:0] d);
    logic got;
    got = 1'b0;
    we[p] = w; addr[p] = a; wdata[p] = d; req[p] = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge SDRAM_CLK);
      got = (p == 0) ? p0_gnt : p1_gnt;
    end
    req[p] = 1'b0;
    if (!got) begin
      n_chk++;
      $display("FAIL grant_timeout: port %0d got no grant, required within 100 cycles", p);
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    m_ack = 1'b1; m_rdy = 1'b1; m_fix = 1'b0; m_rdata = '0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    ARESETn = 1'b1;
    #1 ARESETn = 1'b0;
    #3 check_zero();
    @(negedge SDRAM_CLK);
    @(negedge SDRAM_CLK);
    #2 ARESETn = 1'b1;
    @(negedge SDRAM_CLK);

    // Tie fairness: both ports read back to back, p0 wins the first tie.
    push(K_GNT, 0, 1'b0, 24'h000100, 16'h0000, -1);
    push(K_RV,  0, 1'b0, 24'h000000, 16'hC2C3, 5);
    push(K_GNT, 1, 1'b0, 24'h000201, 16'h0000, 3);
    push(K_RV,  1, 1'b0, 24'h000000, 16'hC1C2, 5);
    push(K_GNT, 0, 1'b0, 24'h000102, 16'h0000, 3);
    push(K_RV,  0, 1'b0, 24'h000000, 16'hC2C1, 5);
    push(K_GNT, 1, 1'b0, 24'h000203, 16'h0000, 3);
    push(K_RV,  1, 1'b0, 24'h000000, 16'hC1C0, 5);
    fork
      begin do_req(0, 1'b0, 24'h000100, 16'h0); do_req(0, 1'b0, 24'h000102, 16'h0); end
      begin do_req(1, 1'b0, 24'h000201, 16'h0); do_req(1, 1'b0, 24'h000203, 16'h0); end
    join
    repeat (12) @(negedge SDRAM_CLK);

    // Single write from p0.
    push(K_GNT, 0, 1'b1, 24'h000010, 16'hBEEF, -1);
    do_req(0, 1'b1, 24'h000010, 16'hBEEF);
    repeat (12) @(negedge SDRAM_CLK);

    // Read return on p1; p0_rdata must keep its last value.
    m_fix = 1'b1; m_rdata = 16'h1234;
    push(K_GNT, 1, 1'b0, 24'h0000A5, 16'h0000, -1);
    push(K_RV,  1, 1'b0, 24'h000000, 16'h1234, 5);
    do_req(1, 1'b0, 24'h0000A5, 16'h0);
    repeat (12) @(negedge SDRAM_CLK);
    m_fix = 1'b0;

    // Ack timeout on a p0 write, then a normal p1 write.
    m_ack = 1'b0;
    push(K_GNT, 0, 1'b1, 24'h000020, 16'h1111, -1);
    push(K_ERR, 0, 1'b0, 24'h000000, 16'h0000, 16);
    push(K_GNT, 1, 1'b1, 24'h000030, 16'h2222, -1);
    do_req(0, 1'b1, 24'h000020, 16'h1111);
    repeat (20) @(negedge SDRAM_CLK);
    m_ack = 1'b1;
    do_req(1, 1'b1, 24'h000030, 16'h2222);
    repeat (12) @(negedge SDRAM_CLK);

    // Read that completes without rd_ready.
    m_rdy = 1'b0;
    push(K_GNT, 0, 1'b0, 24'h000040, 16'h0000, -1);
    push(K_ERR, 0, 1'b0, 24'h000000, 16'h0000, 7);
    do_req(0, 1'b0, 24'h000040, 16'h0);
    repeat (12) @(negedge SDRAM_CLK);
    m_rdy = 1'b1;

    // Reset in the middle of a read, then a tie goes to p0.
    push(K_GNT, 0, 1'b0, 24'h000050, 16'h0000, -1);
    do_req(0, 1'b0, 24'h000050, 16'h0);
    repeat (3) @(negedge SDRAM_CLK);
    #2 ARESETn = 1'b0;
    #1 check_zero();
    repeat (2) @(negedge SDRAM_CLK);
    #2 ARESETn = 1'b1;
    @(negedge SDRAM_CLK);
    push(K_GNT, 0, 1'b1, 24'h000060, 16'h6666, -1);
    push(K_GNT, 1, 1'b1, 24'h000070, 16'h7777, 8);
    fork
      do_req(0, 1'b1, 24'h000060, 16'h6666);
      do_req(1, 1'b1, 24'h000070, 16'h7777);
    join
    repeat (12) @(negedge SDRAM_CLK);

    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
